// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor: a per-PC history table (BHT) indexes
// per-set rows of saturating counters (PHT). History is updated speculatively and repaired on mispredicts.
module local_hist_predictor #(
    parameter int FETCH_WIDTH  = 2,
    parameter int UPDATE_WIDTH = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int INSN_BYTES   = 4,
    parameter int HIST_ENTRIES = 64,
    parameter int HIST_BITS    = 4,
    parameter int PHT_SETS     = 16,
    parameter int CTR_BITS     = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clearReq_i,
    output logic                               ready_o,
    input  logic                               predValid_i,
    input  logic [ADDR_WIDTH-1:0]              predPc_i,
    input  logic [FETCH_WIDTH-1:0]             respCondBr_i,
    output logic                               respValid_o,
    output logic [FETCH_WIDTH-1:0]             respTaken_o,
    output logic [FETCH_WIDTH*HIST_BITS-1:0]   respHist_o,
    output logic [FETCH_WIDTH*CTR_BITS-1:0]    respCtr_o,
    input  logic [UPDATE_WIDTH-1:0]            updValid_i,
    input  logic [UPDATE_WIDTH-1:0]            updTaken_i,
    input  logic [UPDATE_WIDTH-1:0]            updMispred_i,
    input  logic [UPDATE_WIDTH-1:0]            updCondBr_i,
    input  logic [UPDATE_WIDTH*ADDR_WIDTH-1:0] updPc_i,
    input  logic [UPDATE_WIDTH*HIST_BITS-1:0]  updHist_i,
    input  logic [UPDATE_WIDTH*CTR_BITS-1:0]   updCtr_i
);

    localparam int OFS      = $clog2(INSN_BYTES);
    localparam int HI       = $clog2(HIST_ENTRIES);
    localparam int SI       = $clog2(PHT_SETS);
    localparam int PHT_COLS = 1 << HIST_BITS;
    localparam int WALK_LEN = (HIST_ENTRIES > PHT_SETS) ? HIST_ENTRIES : PHT_SETS;
    localparam int WW       = (WALK_LEN > 1) ? $clog2(WALK_LEN) : 1;

    localparam logic [CTR_BITS-1:0] CMAX  = '1;
    localparam logic [CTR_BITS-1:0] CINIT = {1'b1, {(CTR_BITS-1){1'b0}}};

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [WW-1:0]           walkIdx_q, walkIdx_d;
    logic [ADDR_WIDTH-1:0]   predPc_q;
    logic                    respValid_q;

    logic [HIST_BITS-1:0]    bht_q [HIST_ENTRIES];
    logic [HIST_BITS-1:0]    bht_d [HIST_ENTRIES];
    logic [CTR_BITS-1:0]     pht_q [PHT_SETS][PHT_COLS];
    logic [CTR_BITS-1:0]     pht_d [PHT_SETS][PHT_COLS];

    logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] lanePc;
    logic [HI-1:0]           laneIdx  [FETCH_WIDTH];
    logic [SI-1:0]           laneSet  [FETCH_WIDTH];
    logic [HIST_BITS-1:0]    laneHist [FETCH_WIDTH];
    logic [CTR_BITS-1:0]     laneCtr  [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]  laneTaken;
    logic [FETCH_WIDTH-1:0]  laneSpecWr;

    logic [HI-1:0]           updIdx   [UPDATE_WIDTH];
    logic [SI-1:0]           updSet   [UPDATE_WIDTH];
    logic [HIST_BITS-1:0]    updHistW [UPDATE_WIDTH];
    logic [CTR_BITS-1:0]     updCtrW  [UPDATE_WIDTH];
    logic [CTR_BITS-1:0]     trainCtr [UPDATE_WIDTH];
    logic [UPDATE_WIDTH-1:0] trainEn;
    logic [UPDATE_WIDTH-1:0] recovEn;

    logic                    unusedPcBits;

    assign ready_o      = (state_q == ST_RUN);
    assign respValid_o  = respValid_q & (state_q == ST_RUN);
    assign respTaken_o  = laneTaken;
    assign unusedPcBits = ^{lanePc, updPc_i};

    always_comb begin
        state_d   = state_q;
        walkIdx_d = walkIdx_q;
        case (state_q)
            ST_INIT: begin
                if (clearReq_i) begin
                    walkIdx_d = '0;
                end else if (walkIdx_q == WW'(WALK_LEN - 1)) begin
                    state_d   = ST_RUN;
                    walkIdx_d = '0;
                end else begin
                    walkIdx_d = walkIdx_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clearReq_i) begin
                    state_d   = ST_INIT;
                    walkIdx_d = '0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                walkIdx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            walkIdx_q   <= '0;
            respValid_q <= 1'b0;
            predPc_q    <= '0;
        end else begin
            state_q     <= state_d;
            walkIdx_q   <= walkIdx_d;
            respValid_q <= predValid_i & ready_o;
            if (predValid_i && ready_o) begin
                predPc_q <= predPc_i;
            end
        end
    end

    // Lanes after the first predicted-taken lane are on the wrong path: no prediction, no history write.
    always_comb begin : laneRead
        logic blocked;
        blocked    = 1'b0;
        laneTaken  = '0;
        laneSpecWr = '0;
        respHist_o = '0;
        respCtr_o  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lanePc[i]     = predPc_q + ADDR_WIDTH'(i * INSN_BYTES);
            laneIdx[i]    = lanePc[i][OFS +: HI];
            laneSet[i]    = lanePc[i][OFS +: SI];
            laneHist[i]   = bht_q[laneIdx[i]];
            laneCtr[i]    = pht_q[laneSet[i]][laneHist[i]];
            laneSpecWr[i] = respValid_o & respCondBr_i[i] & ~blocked;
            laneTaken[i]  = laneSpecWr[i] & laneCtr[i][CTR_BITS-1];
            blocked       = blocked | laneTaken[i];
            if (respValid_o) begin
                respHist_o[i*HIST_BITS +: HIST_BITS] = laneHist[i];
                respCtr_o[i*CTR_BITS +: CTR_BITS]    = laneCtr[i];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < UPDATE_WIDTH; j++) begin
            updIdx[j]   = updPc_i[j*ADDR_WIDTH + OFS +: HI];
            updSet[j]   = updPc_i[j*ADDR_WIDTH + OFS +: SI];
            updHistW[j] = updHist_i[j*HIST_BITS +: HIST_BITS];
            updCtrW[j]  = updCtr_i[j*CTR_BITS +: CTR_BITS];
            trainEn[j]  = (state_q == ST_RUN) & updValid_i[j] & updCondBr_i[j];
            recovEn[j]  = trainEn[j] & updMispred_i[j];
            if (updTaken_i[j]) begin
                trainCtr[j] = (updCtrW[j] == CMAX) ? updCtrW[j] : updCtrW[j] + 1'b1;
            end else begin
                trainCtr[j] = (updCtrW[j] == '0) ? updCtrW[j] : updCtrW[j] - 1'b1;
            end
        end
    end

    // Write order encodes priority: later assignments win, so recovery runs youngest-to-oldest
    // after the speculative writes, and training runs oldest-to-youngest.
    always_comb begin
        bht_d = bht_q;
        pht_d = pht_q;
        if (state_q == ST_INIT) begin
            if (int'(walkIdx_q) < HIST_ENTRIES) begin
                bht_d[walkIdx_q[HI-1:0]] = '0;
            end
            if (int'(walkIdx_q) < PHT_SETS) begin
                for (int c = 0; c < PHT_COLS; c++) begin
                    pht_d[walkIdx_q[SI-1:0]][c] = CINIT;
                end
            end
        end else begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (laneSpecWr[i]) begin
                    bht_d[laneIdx[i]] = {laneHist[i][HIST_BITS-2:0], laneTaken[i]};
                end
            end
            for (int j = UPDATE_WIDTH - 1; j >= 0; j--) begin
                if (recovEn[j]) begin
                    bht_d[updIdx[j]] = {updHistW[j][HIST_BITS-2:0], updTaken_i[j]};
                end
            end
            for (int j = 0; j < UPDATE_WIDTH; j++) begin
                if (trainEn[j]) begin
                    pht_d[updSet[j]][updHistW[j]] = trainCtr[j];
                end
            end
        end
    end

    // Tables carry no reset so they can map to block RAM; the INIT walk rewrites them.
    always_ff @(posedge clk_i) begin
        bht_q <= bht_d;
        pht_q <= pht_d;
    end

endmodule
